// File: rtl/multiport_register_file_pkg.sv
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared defaults and clear-sequencer state encoding for the
//             multiport register file.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_NUM_REGS = 4;
   localparam int DEF_ADDR_W   = 2;

   // Clear sweep sequencer states
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/multiport_register_file_if.sv
// ============================================================================
//  Module   : multiport_register_file_if
//  Purpose  : Read ports, write port and clear handshake of the register file.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface multiport_register_file_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
);
   logic [ADDR_W-1:0] rs1_addr;
   logic [ADDR_W-1:0] rs2_addr;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              reg_wr_en;
   logic              wr_rdy;
   logic              clr_req;
   logic              clr_busy;

   modport master (
      output rs1_addr, rs2_addr, wr_addr, wr_data, reg_wr_en, clr_req,
      input  rs1_data, rs2_data, wr_rdy, clr_busy
   );

   modport slave (
      input  rs1_addr, rs2_addr, wr_addr, wr_data, reg_wr_en, clr_req,
      output rs1_data, rs2_data, wr_rdy, clr_busy
   );
endinterface

`default_nettype wire

// File: rtl/regfile_clr_seq.sv
// ============================================================================
//  Module   : regfile_clr_seq
//  Purpose  : Sequential clear sweep: on a request, zeroes one register per
//             cycle from index 0 up to NUM_REGS-1, then returns to idle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_clr_seq
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              i_clr_req,
   output logic                   o_clr_busy,
   output logic                   o_clr_we,
   output logic [ADDR_W-1:0]      o_clr_idx
);

   localparam logic [0:0]        S_IDLE  = 1'(IDLE);
   localparam logic [0:0]        S_CLEAR = 1'(CLEAR);
   localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(NUM_REGS - 1);

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_idx;

   // Sweep FSM; requests arriving mid-sweep are ignored
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_clr_req) begin
                  r_state <= S_CLEAR;
                  r_idx   <= '0;
               end
            end
            S_CLEAR: begin
               if (r_idx == c_LAST) begin
                  r_state <= S_IDLE;
                  r_idx   <= '0;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_idx   <= '0;
            end
         endcase
      end
   end

   assign o_clr_busy = (r_state == S_CLEAR);
   assign o_clr_we   = (r_state == S_CLEAR);
   assign o_clr_idx  = r_idx;

endmodule

`default_nettype wire

// File: rtl/multiport_register_file.sv
// ============================================================================
//  Module   : multiport_register_file
//  Purpose  : Two asynchronous read ports, one write port with ready, and a
//             sequential clear sweep. Optional write-to-read bypass is
//             enabled by defining REGFILE_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multiport_register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 0
) (
   input  wire logic                 clk,
   input  wire logic                 reset,
   multiport_register_file_if.slave  bus
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];

   logic              w_clr_busy;
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_idx;
   logic              w_wr_commit;
   logic [DATA_W-1:0] w_rs1_data;
   logic [DATA_W-1:0] w_rs2_data;

   regfile_clr_seq #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_clr_seq (
      .clk        (clk),
      .reset      (reset),
      .i_clr_req  (bus.clr_req),
      .o_clr_busy (w_clr_busy),
      .o_clr_we   (w_clr_we),
      .o_clr_idx  (w_clr_idx)
   );

   assign bus.clr_busy = w_clr_busy;
   assign bus.wr_rdy   = ~w_clr_busy;

   // A write is accepted whenever ready; it only lands if in range and not
   // aimed at a hardwired zero register, otherwise it is silently dropped.
   assign w_wr_commit = bus.reg_wr_en && !w_clr_busy
                        && (int'(bus.wr_addr) < NUM_REGS)
                        && !((ZERO_REG != 0) && (bus.wr_addr == '0));

   // Storage: reset beats the clear sweep, which beats a normal write
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_clr_we) begin
         r_regs[w_clr_idx] <= '0;
      end else if (w_wr_commit) begin
         r_regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Asynchronous read muxes with out-of-range and zero-register masking
   always_comb begin
      w_rs1_data = '0;
      w_rs2_data = '0;
      if ((int'(bus.rs1_addr) < NUM_REGS) && !((ZERO_REG != 0) && (bus.rs1_addr == '0))) begin
         w_rs1_data = r_regs[bus.rs1_addr];
      end
      if ((int'(bus.rs2_addr) < NUM_REGS) && !((ZERO_REG != 0) && (bus.rs2_addr == '0))) begin
         w_rs2_data = r_regs[bus.rs2_addr];
      end
`ifdef REGFILE_BYPASS_EN
      if (w_wr_commit && (bus.wr_addr == bus.rs1_addr)) begin
         w_rs1_data = bus.wr_data;
      end
      if (w_wr_commit && (bus.wr_addr == bus.rs2_addr)) begin
         w_rs2_data = bus.wr_data;
      end
`else
      // Reads show the stored value until the write commits at the edge
`endif
   end

   assign bus.rs1_data = w_rs1_data;
   assign bus.rs2_data = w_rs2_data;

endmodule

`default_nettype wire

// File: tb/tb_multiport_register_file.sv
// ============================================================================
//  Module   : tb_multiport_register_file
//  Purpose  : Self-checking bench for multiport_register_file. Two instances
//             share stimulus: a 4-entry plain file and a 3-entry file with a
//             hardwired zero register (so address 3 is out of range).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multiport_register_file;

   logic clk = 1'b0;
   logic reset;
   int   n_pass  = 0;
   int   n_total = 0;
   bit   chk_en  = 1'b0;

   // Reference state: register contents and remaining sweep cycles per instance
   logic [7:0] mem [2][4];
   int         left [2];

   always #5 clk = ~clk;

   multiport_register_file_if #(.DATA_W(8), .ADDR_W(2)) bus0 ();
   multiport_register_file_if #(.DATA_W(8), .ADDR_W(2)) busz ();

   assign busz.rs1_addr  = bus0.rs1_addr;
   assign busz.rs2_addr  = bus0.rs2_addr;
   assign busz.wr_addr   = bus0.wr_addr;
   assign busz.wr_data   = bus0.wr_data;
   assign busz.reg_wr_en = bus0.reg_wr_en;
   assign busz.clr_req   = bus0.clr_req;

   multiport_register_file #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(2), .ZERO_REG(0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   multiport_register_file #(.DATA_W(8), .NUM_REGS(3), .ADDR_W(2), .ZERO_REG(1)) u_dutz (
      .clk   (clk),
      .reset (reset),
      .bus   (busz)
   );

   function automatic int nr_of(int k);
      return (k == 0) ? 4 : 3;
   endfunction

   function automatic bit lands(int k, logic [1:0] a);
      return (int'(a) < nr_of(k)) && !((k == 1) && (a == 2'd0));
   endfunction

   function automatic logic [7:0] exp_rd(int k, logic [1:0] a);
      logic [7:0] v;
      v = 8'h00;
      if (lands(k, a)) v = mem[k][a];
`ifdef REGFILE_BYPASS_EN
      if (bus0.reg_wr_en && (left[k] == 0) && lands(k, bus0.wr_addr) && (bus0.wr_addr == a))
         v = bus0.wr_data;
`endif
      return v;
   endfunction

   task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      check("rs1_d0",  bus0.rs1_data,          exp_rd(0, bus0.rs1_addr));
      check("rs2_d0",  bus0.rs2_data,          exp_rd(0, bus0.rs2_addr));
      check("busy_d0", 8'(bus0.clr_busy),      8'(left[0] > 0));
      check("rdy_d0",  8'(bus0.wr_rdy),        8'(left[0] == 0));
      check("rs1_dz",  busz.rs1_data,          exp_rd(1, bus0.rs1_addr));
      check("rs2_dz",  busz.rs2_data,          exp_rd(1, bus0.rs2_addr));
      check("busy_dz", 8'(busz.clr_busy),      8'(left[1] > 0));
      check("rdy_dz",  8'(busz.wr_rdy),        8'(left[1] == 0));
   endtask

   // Reference update at a rising edge, straight from the behavioural rules
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            for (int i = 0; i < 4; i++) mem[k][i] = 8'h00;
            left[k] = 0;
         end else if (left[k] > 0) begin
            mem[k][nr_of(k) - left[k]] = 8'h00;
            left[k]--;
         end else begin
            if (bus0.reg_wr_en && lands(k, bus0.wr_addr)) mem[k][bus0.wr_addr] = bus0.wr_data;
            if (bus0.clr_req) left[k] = nr_of(k);
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      if (chk_en) check_model();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_in();
      bus0.reg_wr_en = 1'b0;
      bus0.clr_req   = 1'b0;
      bus0.wr_addr   = 2'd0;
      bus0.wr_data   = 8'h00;
   endtask

   task automatic wr(logic [1:0] a, logic [7:0] d);
      bus0.reg_wr_en = 1'b1;
      bus0.wr_addr   = a;
      bus0.wr_data   = d;
      cycle();
      idle_in();
   endtask

   task automatic read_all();
      for (int a = 0; a < 4; a++) begin
         bus0.rs1_addr = 2'(a);
         bus0.rs2_addr = 2'(3 - a);
         cycle();
      end
   endtask

   task automatic count_busy(string tag, int exp_n, bit poke);
      int n;
      n = 0;
      while (bus0.clr_busy && n < 20) begin
         if (poke && n == 0) begin
            bus0.reg_wr_en = 1'b1;
            bus0.wr_addr   = 2'd1;
            bus0.wr_data   = 8'h99;
         end
         if (poke && n == 1) bus0.clr_req = 1'b1;
         cycle();
         idle_in();
         n++;
      end
      check(tag, 8'(n), 8'(exp_n));
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         left[k] = 0;
         for (int i = 0; i < 4; i++) mem[k][i] = 8'h00;
      end
      reset         = 1'b0;
      bus0.rs1_addr = 2'd0;
      bus0.rs2_addr = 2'd0;
      idle_in();
      cycle();
      cycle();
      reset  = 1'b1;
      chk_en = 1'b1;
      #1;
      check("rst_rs1",  bus0.rs1_data, 8'h00);
      check("rst_rs2",  bus0.rs2_data, 8'h00);
      check("rst_busy", 8'(bus0.clr_busy), 8'h00);
      check("rst_rdy",  8'(bus0.wr_rdy),   8'h01);
      cycle();

      // Basic writes and dual-port reads
      wr(2'd2, 8'hAA);
      wr(2'd3, 8'h55);
      bus0.rs1_addr = 2'd2;
      bus0.rs2_addr = 2'd3;
      #1;
      check("rd_r2", bus0.rs1_data, 8'hAA);
      check("rd_r3", bus0.rs2_data, 8'h55);
      cycle();
      bus0.rs2_addr = 2'd2;
      #1;
      check("same_addr", bus0.rs2_data, 8'hAA);
      cycle();

      // Register 0 write: stored on the plain file, masked on the zero-reg file
      wr(2'd0, 8'hFF);
      bus0.rs1_addr = 2'd0;
      #1;
      check("r0_plain", bus0.rs1_data, 8'hFF);
      check("r0_zero",  busz.rs1_data, 8'h00);
      cycle();

      // Out-of-range write on the 3-entry file is dropped, read returns 0
      wr(2'd3, 8'h77);
      bus0.rs1_addr = 2'd3;
      #1;
      check("oor_read", busz.rs1_data, 8'h00);
      cycle();

      // Fill, then clear; a write during the sweep is refused
      wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
      bus0.clr_req = 1'b1;
      cycle();
      idle_in();
      count_busy("sweep_len", 4, 1'b0);
      read_all();

      // Write alongside the clear request is accepted, then swept away
      wr(2'd0, 8'h5A);
      bus0.clr_req = 1'b1;
      bus0.reg_wr_en = 1'b1;
      bus0.wr_addr = 2'd1;
      bus0.wr_data = 8'hC3;
      cycle();
      idle_in();
      count_busy("sweep_poke", 4, 1'b1);
      read_all();

      // Same-cycle write visibility on a read port
      bus0.rs1_addr  = 2'd1;
      bus0.reg_wr_en = 1'b1;
      bus0.wr_addr   = 2'd1;
      bus0.wr_data   = 8'h3C;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_same", bus0.rs1_data, 8'h3C);
`else
      check("byp_same", bus0.rs1_data, 8'h00);
`endif
      cycle();
      idle_in();
      #1;
      check("byp_next0", bus0.rs1_data, 8'h3C);
      check("byp_nextz", busz.rs1_data, 8'h3C);
      cycle();

      // Reset on sweep cycle 2 aborts the clear
      wr(2'd2, 8'hE7); wr(2'd3, 8'h81);
      bus0.clr_req = 1'b1;
      cycle();
      idle_in();
      cycle();
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      #1;
      check("abort_busy", 8'(bus0.clr_busy), 8'h00);
      read_all();

      // Randomised traffic against the reference
      for (int n = 0; n < 300; n++) begin
         reset          = ($urandom_range(0, 49) != 0);
         bus0.clr_req   = ($urandom_range(0, 15) == 0);
         bus0.reg_wr_en = $urandom_range(0, 1) == 1;
         bus0.wr_addr   = 2'($urandom_range(0, 3));
         bus0.wr_data   = 8'($urandom);
         bus0.rs1_addr  = 2'($urandom_range(0, 3));
         bus0.rs2_addr  = ($urandom_range(0, 3) == 0) ? bus0.wr_addr : 2'($urandom_range(0, 3));
         cycle();
      end
      reset = 1'b1;
      idle_in();
      for (int n = 0; n < 6; n++) cycle();
      read_all();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 Parameter DATA_W, default 8, width of each register and data port.
REQ-002 Parameter NUM_REGS, default 4, number of registers; legal range 2..256.
REQ-003 Parameter ADDR_W, default 2, address width; SHALL satisfy 2**ADDR_W >= NUM_REGS.
REQ-004 Parameter ZERO_REG, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset; asserted when 0.
REQ-007 rs1_addr  in  ADDR_W  read port 1 address.
REQ-008 rs2_addr  in  ADDR_W  read port 2 address.
REQ-009 rs1_data  out  DATA_W  read port 1 data, combinational from rs1_addr.
REQ-010 rs2_data  out  DATA_W  read port 2 data, combinational from rs2_addr.
REQ-011 wr_addr  in  ADDR_W  write address.
REQ-012 wr_data  in  DATA_W  write data.
REQ-013 reg_wr_en  in  1  write request.
REQ-014 wr_rdy  out  1  write accepted this cycle when reg_wr_en & wr_rdy.
REQ-015 clr_req  in  1  one-cycle pulse requesting a full sequential clear.
REQ-016 clr_busy  out  1  high while the clear sweep is in progress.

Function
REQ-017 Accepted write SHALL update register wr_addr at the next rising edge; write latency one cycle.
REQ-018 Reads SHALL be asynchronous; rs1 and rs2 SHALL be independent and may address the same register.
REQ-019 Addresses >= NUM_REGS: reads SHALL return 0, writes SHALL be accepted and discarded.
REQ-020 Clear FSM states: IDLE, CLEAR; IDLE -> CLEAR on clr_req; CLEAR -> IDLE after index NUM_REGS-1 is zeroed.
REQ-021 In CLEAR, one register per cycle SHALL be zeroed, index 0 upward; sweep takes exactly NUM_REGS cycles.
REQ-022 clr_busy SHALL equal (state == CLEAR); wr_rdy SHALL equal ~clr_busy.
REQ-023 Write asserted in the same cycle as clr_req (FSM in IDLE) SHALL be accepted; clear starts the next cycle and will overwrite it.
REQ-024 clr_req while in CLEAR SHALL be ignored (no restart, no extension).
REQ-025 Reads during CLEAR SHALL return current stored contents (swept indices read 0, unswept retain old values).

Reset
REQ-026 reset low at a rising edge SHALL zero all registers in that cycle and force FSM to IDLE, regardless of state.
REQ-027 After reset: clr_busy=0, wr_rdy=1, rs1_data=rs2_data=0.
REQ-028 reset low mid-sweep SHALL abort the sweep; reset takes priority over write and clear.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: when an accepted write targets a read address (and is not to a hardwired zero register), that read port SHALL return wr_data in the same cycle.
REQ-030 REGFILE_BYPASS_EN undefined: read ports SHALL return the pre-write value until the edge commits the write.

Structure
REQ-031 Package regfile_pkg SHALL hold the clear FSM state enum (IDLE, CLEAR) and default DATA_W/NUM_REGS/ADDR_W constants.
REQ-032 Clear sequencer SHALL be sub-module regfile_clr_seq (FSM, sweep index, clr_busy); storage and read muxing stay in top level.

Verification
REQ-033 reset=0 two cycles, then reset=1 -> rs1_data=rs2_data=0x00, clr_busy=0, wr_rdy=1.
REQ-034 Write 0xAA to r2, 0x55 to r3; rs1_addr=2, rs2_addr=3 -> 0xAA, 0x55; same address both ports -> both 0xAA.
REQ-035 ZERO_REG=1: write 0xFF to r0 -> rs1_data(r0)=0x00; ZERO_REG=0 -> 0xFF.
REQ-036 Fill r0..r3 with 0x11..0x44, pulse clr_req -> clr_busy high exactly 4 cycles, wr_rdy low, write of 0x99 to r1 during sweep dropped, all regs 0x00 after.
REQ-037 Write 0x3C to r1 with rs1_addr=1 -> same cycle 0x3C with REGFILE_BYPASS_EN, old value without; both read 0x3C next cycle.
REQ-038 reset low on sweep cycle 2 -> all regs 0x00 next cycle, clr_busy=0; second clr_req during sweep -> still 4 busy cycles total.
